// File: rtl/fifo_arbiter_rr_if.sv
// Handshake bundle between triangle-command producers, the merging arbiter
// and the downstream FIFO write port.
interface fifo_arbiter_rr_if #(
  parameter int WIDTH  = 240,
  parameter int NUM_CH = 2
);
  logic [NUM_CH*WIDTH-1:0] wrdata_in;
  logic [NUM_CH-1:0]       push_in;
  logic [NUM_CH-1:0]       full_out;
  logic [NUM_CH-1:0]       overflow;
  logic [WIDTH-1:0]        wrdata_out;
  logic                    push_out;
  logic                    out_full;

  modport master (
    output wrdata_in, push_in, out_full,
    input  full_out, overflow, wrdata_out, push_out
  );

  modport slave (
    input  wrdata_in, push_in, out_full,
    output full_out, overflow, wrdata_out, push_out
  );
endinterface

// File: rtl/fifo_arbiter_rr.sv
// Buffered N-input round-robin arbiter feeding one downstream FIFO write port.
// Define FIFO_ARB_PRIO0_EN to give channel 0 strict priority over the rest.
module fifo_arb_chbuf #(
  parameter int WIDTH         = 240,
  parameter int LOG_BUF_DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             valid,
  output logic             ovf,
  output logic [WIDTH-1:0] head
);
  localparam int DEPTH = 1 << LOG_BUF_DEPTH;

  logic [WIDTH-1:0]         mem [DEPTH];
  logic [LOG_BUF_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [LOG_BUF_DEPTH:0]   count;
  logic                     wr_en, rd_en;

  // full is a pure register decode, so a pop in the same cycle never frees room
  assign full  = (count == (LOG_BUF_DEPTH+1)'(DEPTH));
  assign valid = (count != '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & valid;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full) ovf <= 1'b1;
    end
  end
endmodule

module fifo_arbiter_rr #(
  parameter int WIDTH         = 240,
  parameter int NUM_CH        = 2,
  parameter int LOG_BUF_DEPTH = 1
) (
  input logic               clk,
  input logic               rst,
  fifo_arbiter_rr_if.slave  bus
);
  localparam int PW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
`ifdef FIFO_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic [NUM_CH-1:0]            elig, pop, full, ovf;
  logic [NUM_CH-1:0][WIDTH-1:0] head;
  logic [PW-1:0]                rr_ptr, grant, rr_next;
  logic                         grant_vld;
  logic [WIDTH-1:0]             data_q;
  logic                         push_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fifo_arb_chbuf #(.WIDTH(WIDTH), .LOG_BUF_DEPTH(LOG_BUF_DEPTH)) u_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.push_in[i]),
      .pop   (pop[i]),
      .data  (bus.wrdata_in[i*WIDTH +: WIDTH]),
      .full  (full[i]),
      .valid (elig[i]),
      .ovf   (ovf[i]),
      .head  (head[i])
    );
  end

  // Walk downward so the closest eligible channel at/after rr_ptr wins last.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant     = '0;
    if (!bus.out_full) begin
      if (PRIO0 && elig[0]) begin
        grant_vld = 1'b1;
      end else begin
        for (int k = NUM_CH - 1; k >= 0; k--) begin
          idx = int'(rr_ptr) + k;
          if (idx >= NUM_CH) idx = idx - NUM_CH;
          if (elig[idx]) begin
            grant_vld = 1'b1;
            grant     = PW'(idx);
          end
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    if (grant_vld) pop[grant] = 1'b1;
  end

  assign rr_next = (grant == PW'(NUM_CH - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      push_q <= 1'b0;
      data_q <= '0;
    end else begin
      push_q <= grant_vld;
      if (grant_vld) begin
        data_q <= head[grant];
        // strict-priority grants of channel 0 leave the rotation untouched
        if (!(PRIO0 && grant == '0)) rr_ptr <= rr_next;
      end
    end
  end

  assign bus.full_out   = full;
  assign bus.overflow   = ovf;
  assign bus.wrdata_out = data_q;
  assign bus.push_out   = push_q;
endmodule
